eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer.sv | 204 ++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - GMII transmit framer: preamble/SFD, 8-byte delay line, optional pad (ETH_TX_FRAMER_PAD_EN), CRC-32 FCS, IFG

// One-byte CRC-32 update, reflected polynomial, data consumed LSB first
module eth_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Bit-serial LFSR unrolled over the eight data bits
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

module eth_tx_framer #(
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic [7:0] o_gmii_txd,
  output logic       o_gmii_tx_en,
  output logic       o_busy,
  output logic       o_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
`ifdef ETH_TX_FRAMER_PAD_EN
    PAD,
`endif
    FCS,
    IFG
  } state_t;

  localparam logic [15:0] IFG16 = 16'(IFG_BYTES);
`ifdef ETH_TX_FRAMER_PAD_EN
  localparam logic [15:0] MIN16 = 16'(MIN_FRAME_BYTES);
`else
  logic [31:0] unused_min;
  assign unused_min = MIN_FRAME_BYTES;
`endif

  state_t      state, state_n;
  logic [15:0] phase_cnt, phase_n;
  logic [15:0] byte_cnt, cnt_n, cnt_inc;
  logic [31:0] crc, crc_n, crc_next, fcs;
  logic [7:0]  crc_byte;
  logic [7:0]  dl_data [8];
  logic [7:0]  dl_vld;
  logic        valid_d, run_active, run_n;
  logic        rise, start, shift_vld;
  logic [7:0]  txd_n;
  logic        tx_en_n, overrun_n;
  logic [7:0]  txd_q;
  logic        tx_en_q, busy_q, overrun_q;

  // A frame may only start on a fresh rising edge while idle; later bytes of
  // that run follow it into the delay line, any other run is dropped.
  assign rise      = i_data_valid & ~valid_d;
  assign start     = rise && (state == IDLE);
  assign shift_vld = i_data_valid & (start | run_active);
  assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign crc_byte  = (state == DATA && dl_vld[7]) ? dl_data[7] : 8'h00;
  assign fcs       = ~crc;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  // Next-state and next-output decode; each branch produces the byte for the coming cycle
  always_comb begin
    state_n   = state;
    phase_n   = phase_cnt;
    cnt_n     = byte_cnt;
    crc_n     = crc;
    txd_n     = 8'h00;
    tx_en_n   = 1'b0;
    overrun_n = rise && (state != IDLE);
    run_n     = i_data_valid && (start || run_active);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PREAMBLE;
          txd_n   = 8'h55;
          tx_en_n = 1'b1;
          phase_n = 16'd1;
          cnt_n   = 16'd0;
          crc_n   = 32'hFFFFFFFF;
        end
      end
      PREAMBLE: begin
        tx_en_n = 1'b1;
        if (phase_cnt == 16'd7) begin
          txd_n   = 8'hD5;
          state_n = DATA;
        end else begin
          txd_n   = 8'h55;
          phase_n = phase_cnt + 16'd1;
        end
      end
      DATA: begin
        tx_en_n = 1'b1;
        if (dl_vld[7]) begin
          txd_n = dl_data[7];
          cnt_n = cnt_inc;
          crc_n = crc_next;
        end
`ifdef ETH_TX_FRAMER_PAD_EN
        else if (byte_cnt < MIN16) begin
          state_n = PAD;
          cnt_n   = cnt_inc;
          crc_n   = crc_next;
        end
`endif
        else begin
          state_n = FCS;
          txd_n   = fcs[7:0];
          phase_n = 16'd1;
        end
      end
`ifdef ETH_TX_FRAMER_PAD_EN
      PAD: begin
        tx_en_n = 1'b1;
        if (byte_cnt < MIN16) begin
          cnt_n = cnt_inc;
          crc_n = crc_next;
        end else begin
          state_n = FCS;
          txd_n   = fcs[7:0];
          phase_n = 16'd1;
        end
      end
`endif
      FCS: begin
        if (phase_cnt == 16'd4) begin
          state_n = IFG;
          phase_n = 16'd1;
        end else begin
          tx_en_n = 1'b1;
          txd_n   = 8'(fcs >> {phase_cnt[1:0], 3'b000});
          phase_n = phase_cnt + 16'd1;
        end
      end
      IFG: begin
        if (phase_cnt >= IFG16) state_n = IDLE;
        else                    phase_n = phase_cnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, CRC, delay line and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      phase_cnt  <= 16'd0;
      byte_cnt   <= 16'd0;
      crc        <= 32'hFFFFFFFF;
      dl_vld     <= 8'h00;
      valid_d    <= 1'b0;
      run_active <= 1'b0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < 8; i++) dl_data[i] <= 8'h00;
    end else begin
      state      <= state_n;
      phase_cnt  <= phase_n;
      byte_cnt   <= cnt_n;
      crc        <= crc_n;
      dl_vld     <= {dl_vld[6:0], shift_vld};
      valid_d    <= i_data_valid;
      run_active <= run_n;
      txd_q      <= txd_n;
      tx_en_q    <= tx_en_n;
      busy_q     <= (state_n != IDLE);
      overrun_q  <= overrun_n;
      dl_data[0] <= i_data;
      for (int i = 1; i < 8; i++) dl_data[i] <= dl_data[i-1];
    end
  end

  assign o_gmii_txd   = txd_q;
  assign o_gmii_tx_en = tx_en_q;
  assign o_busy       = busy_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - directed self-checking bench for eth_tx_framer
module tb_eth_tx_framer;

  localparam int MIN_FRAME = 60;
  localparam int IFG       = 12;
`ifdef ETH_TX_FRAMER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;
  logic [7:0] txd;
  logic       tx_en, busy, overrun;

  int checks = 0, passed = 0;
  int cyc = 0;
  int bursts = 0, ovr = 0, idle_bad = 0;
  int first_en_cyc = 0, last_en_cyc = 0, busy_fall_cyc = 0, start_cyc = 0;
  logic en_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] frm[$];

  eth_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME_BYTES(MIN_FRAME)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (din),
    .i_data_valid (vld),
    .o_gmii_txd   (txd),
    .o_gmii_tx_en (tx_en),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture what appears on GMII, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      if (!en_prev) begin
        bursts++;
        first_en_cyc = cyc;
      end
      cap.push_back(txd);
      last_en_cyc = cyc;
    end else if (txd !== 8'h00) begin
      idle_bad++;
    end
    if (overrun === 1'b1) ovr++;
    if (busy_prev && busy === 1'b0) busy_fall_cyc = cyc;
    en_prev   = (tx_en === 1'b1);
    busy_prev = (busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic clr();
    cap.delete();
    bursts = 0;
    ovr    = 0;
  endtask

  task automatic send_frm();
    for (int i = 0; i < frm.size(); i++) begin
      if (i == 0) start_cyc = cyc;
      din = frm[i];
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    din = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] body[$];
    logic [7:0] e[$];
    logic [31:0] c;
    int nbad;
    body = frm;
    if (PAD_EN) while (body.size() < MIN_FRAME) body.push_back(8'h00);
    c = ~crc32(body);
    e = {};
    repeat (7) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (body[i]) e.push_back(body[i]);
    for (int k = 0; k < 4; k++) e.push_back(8'(c >> (8 * k)));
    check({tag, "_len"}, cap.size(), e.size());
    nbad = 0;
    for (int i = 0; i < e.size(); i++)
      if (i >= cap.size() || cap[i] !== e[i]) nbad++;
    check({tag, "_bad_bytes"}, nbad, 0);
    check({tag, "_bursts"}, bursts, 1);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    vld   = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd",     {24'b0, txd},     32'h0);
    check("rst_tx_en",   {31'b0, tx_en},   32'h0);
    check("rst_busy",    {31'b0, busy},    32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    idle_bad = 0;

    // "123456789"
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frm();
    wait_idle("t1");
    check_frame("t1");
    check("t1_len_lit", cap.size(), PAD_EN ? 72 : 21);
`ifndef ETH_TX_FRAMER_PAD_EN
    w = (cap.size() >= 21) ? {cap[20], cap[19], cap[18], cap[17]} : 32'h0;
    check("t1_fcs_lit", w, 32'hCBF43926);
`endif
    check("t1_ifg_gap", busy_fall_cyc - last_en_cyc, IFG + 1);
    clr();

    // single byte 0xAB
    frm = {8'hAB};
    send_frm();
    wait_idle("t2");
    check_frame("t2");
    check("t2_len_lit", cap.size(), PAD_EN ? 72 : 13);
    clr();

    // 42 bytes
    frm = {};
    for (int i = 0; i < 42; i++) frm.push_back(8'(i * 7 + 3));
    send_frm();
    wait_idle("t3");
    check_frame("t3");
    check("t3_len_lit", cap.size(), PAD_EN ? 72 : 54);
    clr();

    // 100 bytes, latency of D0
    frm = {};
    for (int i = 0; i < 100; i++) frm.push_back(8'(i) ^ 8'h5A);
    send_frm();
    wait_idle("t4");
    check_frame("t4");
    check("t4_len_lit", cap.size(), 112);
    check("t4_first_en", first_en_cyc, start_cyc + 1);
    check("t4_d0_pos", (cap.size() > 8) ? {24'b0, cap[8]} : 32'hFFFF, 32'h5A);
    clr();

    // overrun: second run rises 5 cycles after last byte and is still high at IDLE
    frm = {};
    for (int i = 0; i < 10; i++) frm.push_back(8'hA0 + 8'(i));
    send_frm();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      din = 8'hEE;
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    din = 8'h00;
    wait_idle("t5a");
    repeat (5) @(negedge clk);
    check("t5_overrun_pulses", ovr, 1);
    check_frame("t5a");
    clr();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frm();
    wait_idle("t5c");
    check_frame("t5c");
    check("t5c_no_overrun", ovr, 0);
    clr();

    // reset pulse while data byte 20 is sampled
    frm = {};
    for (int i = 0; i < 20; i++) begin
      din = 8'(i);
      vld = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    vld   = 1'b0;
    din   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_tx_en_after_rst", {31'b0, tx_en}, 32'h0);
    check("t6_busy_after_rst",  {31'b0, busy},  32'h0);
    repeat (30) @(negedge clk);
    check("t6_cap_len", cap.size(), 20);
    check("t6_bursts", bursts, 1);
    clr();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frm();
    wait_idle("t6b");
    check_frame("t6b");
    clr();

    check("idle_txd_nonzero", idle_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
